fe_diag_seq: RTL and testbench

//  Synthesizable front-end diagnostic sequencer. It drives CLK-module diagnostic

---
 rtl/fe_diag_seq.sv | 336 +++++++++++++++++++++++++++++++++
 tb/tb_fe_diag_seq.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fe_diag_seq.sv
// ---------------------------------------------------------------------------
// fe_diag_seq -- front-end diagnostic sequencer
//
// Pops commands from a small FIFO and plays them onto the EBUS diag interface
// as timed ds/strobe pulses (FUNC, WRITE, READ), or runs a bounded
// step-and-check loop against sync_cond (SYNC). READ and SYNC report through
// a one-cycle response pulse. An abort flushes the queue and cuts the current
// command short.
//
// Ports
//   clk, reset_l                    clock, async active-low reset
//   cmd_valid/cmd_ready             command handshake (ready = FIFO has room)
//   cmd_op/cmd_func/cmd_data        0=FUNC 1=WRITE 2=READ 3=SYNC, ds code, data
//   abort                           flush queue, terminate current command
//   ebus_ds/ebus_diag_strobe        diag function select and strobe
//   ebus_drive/ebus_data_out        sequencer-owned EBUS data (WRITE only)
//   ebus_data_in                    EBUS return data sampled by READ
//   sync_cond                       condition polled by SYNC
//   rsp_valid/rsp_data/rsp_err      READ data or SYNC try count, error flag
//   sync_fail                       sticky SYNC-exhausted flag
//   busy                            sequencer active or queue non-empty
// ---------------------------------------------------------------------------
module fe_diag_seq #(
   parameter int unsigned     DS_W       = 7,
   parameter int unsigned     DATA_W     = 36,
   parameter int unsigned     DEPTH      = 8,
   parameter int unsigned     HOLD_CYC   = 9,
   parameter int unsigned     RECOV_CYC  = 4,
   parameter int unsigned     SETTLE_CYC = 5,
   parameter int unsigned     MAX_TRIES  = 5,
   parameter logic [DS_W-1:0] STEP_FUNC  = 7'o2
) (
   input  logic              clk,
   input  logic              reset_l,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [DS_W-1:0]   cmd_func,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic              abort,
   output logic [DS_W-1:0]   ebus_ds,
   output logic              ebus_diag_strobe,
   output logic              ebus_drive,
   output logic [DATA_W-1:0] ebus_data_out,
   input  logic [DATA_W-1:0] ebus_data_in,
   input  logic              sync_cond,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              sync_fail,
   output logic              busy
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CW    = AW + 1;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

   localparam logic [1:0] OP_FUNC  = 2'd0;
   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_READ  = 2'd2;
   localparam logic [1:0] OP_SYNC  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_RECOVER = 2'd2,
      ST_SETTLE  = 2'd3
   } state_e;

   // command FIFO storage and pointers
   logic [1:0]        op_mem   [DEPTH];
   logic [DS_W-1:0]   func_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q, count_d;
   logic              empty_s, full_s, push_s, pop_s, start_s, rdy_q;

   // sequencer state and the command being executed
   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        op_q, op_d;
   logic [DS_W-1:0]   func_q, func_d;
   logic [DATA_W-1:0] data_q, data_d, rd_q, rd_d;
   logic              step_q, step_d;      // current ASSERT is a SYNC step
   logic              abt_q, abt_d;        // current command has been aborted
   logic [TRY_W-1:0]  tries_q, tries_d;
   logic              fail_q, fail_d;
   logic              rsp_v_d, rsp_err_d;
   logic [DATA_W-1:0] rsp_data_d;

   // registered outputs
   logic [DS_W-1:0]   ds_q;
   logic              strobe_q, drive_q, rsp_v_q, rsp_err_q, busy_q;
   logic [DATA_W-1:0] dout_q, rsp_data_q;

   assign empty_s = (count_q == CW'(0));
   assign full_s  = (count_q == CW'(DEPTH));
   // a full FIFO still accepts when the head is leaving this same cycle
   assign cmd_ready = rdy_q && (!full_s || pop_s);
   assign push_s    = cmd_valid && cmd_ready && !abort;

   // FIFO occupancy next value; abort flushes and blocks push/pop
   always_comb begin
      count_d = count_q;
      if (abort) begin
         count_d = '0;
      end else begin
         count_d = count_q + CW'(push_s) - CW'(pop_s);
      end
   end

   // Sequencer next-state, command latch and response decode
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + CNT_W'(1);
      op_d       = op_q;
      func_d     = func_q;
      data_d     = data_q;
      step_d     = step_q;
      tries_d    = tries_q;
      abt_d      = abt_q;
      rd_d       = rd_q;
      fail_d     = fail_q;
      rsp_v_d    = 1'b0;
      rsp_data_d = '0;
      rsp_err_d  = 1'b0;
      start_s    = 1'b0;
      pop_s      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!abort && !empty_s) begin
               start_s = 1'b1;
            end else begin
               start_s = 1'b0;
            end
         end
         ST_ASSERT: begin
            if (abort) begin
               abt_d   = 1'b1;
               state_d = ST_RECOVER;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
               state_d = ST_RECOVER;
               cnt_d   = '0;
               if (op_q == OP_READ) begin
                  rd_d = ebus_data_in;
               end else begin
                  rd_d = rd_q;
               end
            end else begin
               state_d = ST_ASSERT;
            end
         end
         ST_RECOVER: begin
            if (abort) begin
               abt_d = 1'b1;
            end else begin
               abt_d = abt_q;
            end
            if (cnt_q == CNT_W'(RECOV_CYC - 1)) begin
               cnt_d = '0;
               if (abt_d) begin
                  state_d = ST_IDLE;
                  if (op_q == OP_READ || op_q == OP_SYNC) begin
                     rsp_v_d    = 1'b1;
                     rsp_err_d  = 1'b1;
                     rsp_data_d = (op_q == OP_SYNC) ? DATA_W'(tries_q) : '0;
                  end else begin
                     rsp_v_d = 1'b0;
                  end
               end else if (step_q) begin
                  state_d = ST_SETTLE;
               end else begin
                  if (op_q == OP_READ) begin
                     rsp_v_d    = 1'b1;
                     rsp_data_d = rd_q;
                  end else begin
                     rsp_v_d = 1'b0;
                  end
                  // pop straight from RECOVER so back-to-back asserts have no gap
                  if (!empty_s) begin
                     start_s = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end else begin
               state_d = ST_RECOVER;
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               rsp_v_d    = 1'b1;
               rsp_err_d  = 1'b1;
               rsp_data_d = DATA_W'(tries_q);
               state_d    = ST_IDLE;
               cnt_d      = '0;
            end else if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
               cnt_d = '0;
               if (!sync_cond) begin
                  rsp_v_d    = 1'b1;
                  rsp_data_d = DATA_W'(tries_q);
                  state_d    = ST_IDLE;
               end else if (tries_q < TRY_W'(MAX_TRIES)) begin
                  tries_d = tries_q + TRY_W'(1);
                  step_d  = 1'b1;
                  func_d  = STEP_FUNC;
                  state_d = ST_ASSERT;
               end else begin
                  rsp_v_d    = 1'b1;
                  rsp_err_d  = 1'b1;
                  rsp_data_d = DATA_W'(tries_q);
                  fail_d     = 1'b1;
                  state_d    = ST_IDLE;
               end
            end else begin
               state_d = ST_SETTLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      if (start_s) begin
         pop_s  = 1'b1;
         op_d   = op_mem[rd_ptr_q];
         func_d = func_mem[rd_ptr_q];
         data_d = data_mem[rd_ptr_q];
         step_d = 1'b0;
         abt_d  = 1'b0;
         cnt_d  = '0;
         if (op_mem[rd_ptr_q] == OP_SYNC) begin
            state_d = ST_SETTLE;
            tries_d = '0;
         end else begin
            state_d = ST_ASSERT;
         end
      end else begin
         pop_s = 1'b0;
      end
   end

   // FIFO storage write (data only, no reset needed)
   always_ff @(posedge clk) begin
      if (push_s) begin
         op_mem[wr_ptr_q]   <= cmd_op;
         func_mem[wr_ptr_q] <= cmd_func;
         data_mem[wr_ptr_q] <= cmd_data;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rdy_q    <= 1'b0;
      end else begin
         rdy_q   <= 1'b1;
         count_q <= count_d;
         if (abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
         end
      end
   end

   // Sequencer state and command registers
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= OP_FUNC;
         func_q  <= '0;
         data_q  <= '0;
         rd_q    <= '0;
         step_q  <= 1'b0;
         abt_q   <= 1'b0;
         tries_q <= '0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         func_q  <= func_d;
         data_q  <= data_d;
         rd_q    <= rd_d;
         step_q  <= step_d;
         abt_q   <= abt_d;
         tries_q <= tries_d;
         fail_q  <= fail_d;
      end
   end

   // Output registers, decoded from next state so pins line up with the state
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         ds_q       <= '0;
         strobe_q   <= 1'b0;
         drive_q    <= 1'b0;
         dout_q     <= '0;
         rsp_v_q    <= 1'b0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         ds_q       <= (state_d == ST_ASSERT) ? func_d : '0;
         strobe_q   <= (state_d == ST_ASSERT);
         // drive is qualified by the same ASSERT term as strobe
         drive_q    <= (state_d == ST_ASSERT) && (op_d == OP_WRITE);
         dout_q     <= ((state_d == ST_ASSERT) && (op_d == OP_WRITE)) ? data_d : '0;
         rsp_v_q    <= rsp_v_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
         busy_q     <= (state_d != ST_IDLE) || (count_d != CW'(0));
      end
   end

   assign ebus_ds          = ds_q;
   assign ebus_diag_strobe = strobe_q;
   assign ebus_drive       = drive_q;
   assign ebus_data_out    = dout_q;
   assign rsp_valid        = rsp_v_q;
   assign rsp_data         = rsp_data_q;
   assign rsp_err          = rsp_err_q;
   assign sync_fail        = fail_q;
   assign busy             = busy_q;

endmodule

// File: tb/tb_fe_diag_seq.sv
module tb_fe_diag_seq;
   localparam int HOLD  = 9;
   localparam int RECOV = 4;
   localparam logic [6:0] STEP = 7'o2;
   localparam logic [1:0] OP_FUNC = 2'd0, OP_WRITE = 2'd1, OP_READ = 2'd2, OP_SYNC = 2'd3;

   logic        clk = 1'b0;
   logic        reset_l, cmd_valid, cmd_ready, abort, sync_cond;
   logic [1:0]  cmd_op;
   logic [6:0]  cmd_func, ebus_ds;
   logic [35:0] cmd_data, ebus_data_out, ebus_data_in, rsp_data;
   logic        ebus_diag_strobe, ebus_drive, rsp_valid, rsp_err, sync_fail, busy;

   always #5 clk = ~clk;

   fe_diag_seq dut (
      .clk(clk), .reset_l(reset_l), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_func(cmd_func), .cmd_data(cmd_data), .abort(abort),
      .ebus_ds(ebus_ds), .ebus_diag_strobe(ebus_diag_strobe), .ebus_drive(ebus_drive),
      .ebus_data_out(ebus_data_out), .ebus_data_in(ebus_data_in), .sync_cond(sync_cond),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .sync_fail(sync_fail), .busy(busy)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [35:0] data;
      logic        err;
      logic        chk_data;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   // response scoreboard and drive/strobe invariant, sampled on the falling edge
   always @(negedge clk) begin
      if (reset_l === 1'b1) begin
         if (ebus_drive === 1'b1) begin
            checks++;
            if (ebus_diag_strobe !== 1'b1) begin
               errors++;
               $display("FAIL drive_no_strobe: strobe=%0b required 1 while drive=1", ebus_diag_strobe);
            end
         end
         if (rsp_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL rsp_unexpected: rsp_valid=1 data=%0o err=%0b, none required", rsp_data, rsp_err);
            end else begin
               mon_e = sb.pop_front();
               if (rsp_err !== mon_e.err || (mon_e.chk_data && rsp_data !== mon_e.data)) begin
                  errors++;
                  $display("FAIL rsp: data=%0o err=%0b required data=%0o err=%0b",
                           rsp_data, rsp_err, mon_e.data, mon_e.err);
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] op, input logic [6:0] fn, input logic [35:0] d,
                       output int waited);
      logic acc;
      acc = 1'b0;
      waited = 0;
      cmd_op = op; cmd_func = fn; cmd_data = d; cmd_valid = 1'b1;
      while (!acc && waited < 300) begin
         #1;
         acc = cmd_ready;
         tick();
         if (!acc) waited++;
      end
      cmd_valid = 1'b0;
      if (!acc) begin
         checks++; errors++;
         $display("FAIL push_timeout: cmd_ready stayed 0 for %0d cycles, required 1", waited);
      end
   endtask

   task automatic wait_strobe(input logic lvl, input string tag);
      int n;
      n = 0;
      while (ebus_diag_strobe !== lvl && n < 300) begin
         tick(); n++;
      end
      if (ebus_diag_strobe !== lvl) begin
         checks++; errors++;
         $display("FAIL %s: strobe=%0b after %0d cycles, required %0b", tag, ebus_diag_strobe, n, lvl);
      end
   endtask

   task automatic wait_idle(input string tag, output int n);
      n = 0;
      while (busy === 1'b1 && n < 1000) begin
         tick(); n++;
      end
      if (busy !== 1'b0) begin
         checks++; errors++;
         $display("FAIL %s: busy=%0b after %0d cycles, required 0", tag, busy, n);
      end
   endtask

   task automatic test_reset();
      logic [85:0] v;
      reset_l = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_func = '0; cmd_data = '0;
      abort = 1'b0; sync_cond = 1'b0; ebus_data_in = '0;
      repeat (3) tick();
      v = {ebus_ds, ebus_diag_strobe, ebus_drive, ebus_data_out, rsp_valid, rsp_data,
           rsp_err, sync_fail, busy, cmd_ready};
      checks++;
      if (v !== 86'd0) begin
         errors++;
         $display("FAIL reset_outputs: outputs=%0h required 0", v);
      end
      @(negedge clk);
      reset_l = 1'b1;
      tick();
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: cmd_ready=%0b busy=%0b required 1 0", cmd_ready, busy);
      end
   endtask

   task automatic test_func();
      int w, n, good, m;
      push(OP_FUNC, 7'o10, 36'd0, w);
      wait_strobe(1'b1, "func_start");
      n = 0; good = 0;
      while (ebus_diag_strobe === 1'b1 && n < 300) begin
         n++;
         if (ebus_ds === 7'o10 && ebus_drive === 1'b0) good++;
         tick();
      end
      checks++;
      if (n != HOLD) begin
         errors++; $display("FAIL func_hold: strobe cycles=%0d required %0d", n, HOLD);
      end
      checks++;
      if (good != HOLD) begin
         errors++; $display("FAIL func_ds: good ds cycles=%0d required %0d", good, HOLD);
      end
      wait_idle("func_idle", m);
      checks++;
      if (m != RECOV) begin
         errors++; $display("FAIL func_recover: busy-low-strobe cycles=%0d required %0d", m, RECOV);
      end
   endtask

   task automatic test_write_func();
      int w, n, good, g, bad;
      push(OP_WRITE, 7'o44, 36'o120, w);
      push(OP_FUNC, 7'o4, 36'd0, w);
      wait_strobe(1'b1, "write_start");
      n = 0; good = 0;
      while (ebus_diag_strobe === 1'b1 && n < 300) begin
         n++;
         if (ebus_ds === 7'o44 && ebus_drive === 1'b1 && ebus_data_out === 36'o120) good++;
         tick();
      end
      checks++;
      if (n != HOLD || good != HOLD) begin
         errors++; $display("FAIL write_assert: cycles=%0d good=%0d required %0d", n, good, HOLD);
      end
      g = 0; bad = 0;
      while (ebus_diag_strobe === 1'b0 && g < 300) begin
         if (ebus_drive !== 1'b0) bad++;
         g++; tick();
      end
      checks++;
      if (g != RECOV || bad != 0) begin
         errors++; $display("FAIL b2b_gap: idle cycles=%0d drive_bad=%0d required %0d 0", g, bad, RECOV);
      end
      n = 0; good = 0;
      while (ebus_diag_strobe === 1'b1 && n < 300) begin
         n++;
         if (ebus_ds === 7'o4 && ebus_drive === 1'b0) good++;
         tick();
      end
      checks++;
      if (n != HOLD || good != HOLD) begin
         errors++; $display("FAIL func2_assert: cycles=%0d good=%0d required %0d", n, good, HOLD);
      end
      wait_idle("write_idle", n);
   endtask

   task automatic test_read();
      int w, k;
      ebus_data_in = 36'o000000000040;
      sb.push_back('{36'o40, 1'b0, 1'b1});
      push(OP_READ, 7'o162, 36'd0, w);
      wait_strobe(1'b1, "read_start");
      wait_strobe(1'b0, "read_end");
      k = 0;
      while (rsp_valid !== 1'b1 && k < 50) begin
         tick(); k++;
      end
      checks++;
      if (k != RECOV) begin
         errors++; $display("FAIL read_latency: cycles after strobe=%0d required %0d", k, RECOV);
      end
      wait_idle("read_idle", w);
      ebus_data_in = '0;
   endtask

   task automatic test_sync();
      int w, steps, bad, n;
      logic prev;
      // condition true for two samples, then released
      sync_cond = 1'b1;
      sb.push_back('{36'd2, 1'b0, 1'b1});
      push(OP_SYNC, 7'o77, 36'd0, w);
      steps = 0; bad = 0; prev = 1'b0; n = 0;
      while (busy === 1'b1 && n < 1000) begin
         if (ebus_diag_strobe === 1'b1 && !prev) begin
            steps++;
            if (ebus_ds !== STEP) bad++;
            if (steps == 2) sync_cond = 1'b0;
         end
         prev = ebus_diag_strobe;
         tick(); n++;
      end
      checks++;
      if (steps != 2 || bad != 0 || sync_fail !== 1'b0) begin
         errors++;
         $display("FAIL sync_ok: steps=%0d bad_ds=%0d sync_fail=%0b required 2 0 0", steps, bad, sync_fail);
      end
      // condition stuck true: exhausts the try budget
      sync_cond = 1'b1;
      sb.push_back('{36'd5, 1'b1, 1'b1});
      push(OP_SYNC, 7'o0, 36'd0, w);
      steps = 0; prev = 1'b0; n = 0;
      while (busy === 1'b1 && n < 2000) begin
         if (ebus_diag_strobe === 1'b1 && !prev) steps++;
         prev = ebus_diag_strobe;
         tick(); n++;
      end
      checks++;
      if (steps != 5 || sync_fail !== 1'b1) begin
         errors++;
         $display("FAIL sync_exhaust: steps=%0d sync_fail=%0b required 5 1", steps, sync_fail);
      end
      sync_cond = 1'b0;
   endtask

   task automatic test_back_to_back();
      int w, idx, bad, n;
      logic prev;
      logic [6:0] exp_f [9];
      push(OP_FUNC, 7'o1, 36'd0, w);
      for (int i = 0; i < 9; i++) exp_f[i] = 7'(7'o20 + i);
      for (int i = 0; i < 8; i++) push(OP_FUNC, exp_f[i], 36'd0, w);
      #1;
      checks++;
      if (cmd_ready !== 1'b0) begin
         errors++; $display("FAIL fifo_full: cmd_ready=%0b required 0", cmd_ready);
      end
      push(OP_FUNC, exp_f[8], 36'd0, w);
      checks++;
      if (w == 0 || ebus_diag_strobe !== 1'b1 || ebus_ds !== exp_f[0]) begin
         errors++;
         $display("FAIL full_accept: waited=%0d strobe=%0b ds=%0o required >0 1 %0o",
                  w, ebus_diag_strobe, ebus_ds, exp_f[0]);
      end
      idx = 0; bad = 0; prev = 1'b0; n = 0;
      while (busy === 1'b1 && n < 1000) begin
         if (ebus_diag_strobe === 1'b1 && !prev) begin
            if (idx < 9 && ebus_ds !== exp_f[idx]) bad++;
            idx++;
         end
         prev = ebus_diag_strobe;
         tick(); n++;
      end
      checks++;
      if (idx != 9 || bad != 0) begin
         errors++; $display("FAIL fifo_order: asserts=%0d bad=%0d required 9 0", idx, bad);
      end
   endtask

   task automatic test_abort();
      int w, m, rises;
      logic prev;
      push(OP_READ, 7'o162, 36'd0, w);
      push(OP_FUNC, 7'o31, 36'd0, w);
      push(OP_FUNC, 7'o32, 36'd0, w);
      push(OP_FUNC, 7'o33, 36'd0, w);
      checks++;
      if (ebus_diag_strobe !== 1'b1 || ebus_ds !== 7'o162) begin
         errors++; $display("FAIL abort_setup: strobe=%0b ds=%0o required 1 162", ebus_diag_strobe, ebus_ds);
      end
      sb.push_back('{36'd0, 1'b1, 1'b0});
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (ebus_diag_strobe !== 1'b0) begin
         errors++; $display("FAIL abort_strobe: strobe=%0b required 0", ebus_diag_strobe);
      end
      m = 0; rises = 0; prev = 1'b0;
      while (busy === 1'b1 && m < 300) begin
         if (ebus_diag_strobe === 1'b1 && !prev) rises++;
         prev = ebus_diag_strobe;
         tick(); m++;
      end
      checks++;
      if (m != RECOV || rises != 0) begin
         errors++; $display("FAIL abort_flush: busy cycles=%0d asserts=%0d required %0d 0", m, rises, RECOV);
      end
   endtask

   task automatic test_reset_mid();
      int w;
      push(OP_WRITE, 7'o20, 36'o777, w);
      wait_strobe(1'b1, "rst_start");
      tick(); tick();
      reset_l = 1'b0;
      #1;
      checks++;
      if (ebus_diag_strobe !== 1'b0 || ebus_ds !== 7'd0 || ebus_drive !== 1'b0 ||
          busy !== 1'b0 || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: strobe=%0b ds=%0o drive=%0b busy=%0b ready=%0b required all 0",
                  ebus_diag_strobe, ebus_ds, ebus_drive, busy, cmd_ready);
      end
      tick();
      @(negedge clk);
      reset_l = 1'b1;
      tick();
      checks++;
      if (cmd_ready !== 1'b1 || sync_fail !== 1'b0) begin
         errors++; $display("FAIL reset_mid_release: ready=%0b sync_fail=%0b required 1 0", cmd_ready, sync_fail);
      end
   endtask

   initial begin
      test_reset();
      test_func();
      test_write_func();
      test_read();
      test_sync();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      repeat (3) tick();
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL rsp_missing: %0d responses outstanding, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
